// File: rtl/jedro_1_issue_ctrl.sv
// jedro_1_issue_ctrl: decode-stage issue scheduler (scoreboard, load limit, serialization, post-jump flush)
module jedro_1_issue_ctrl #(
   parameter int REG_ADDR_WIDTH = 5,
   parameter int MAX_LOADS      = 2,
   parameter int FLUSH_CYCLES   = 2
) (
   input  logic                         clk_i,
   input  logic                         rstn_i,
   input  logic                         issue_valid_i,
   output logic                         issue_ready_o,
   input  logic [REG_ADDR_WIDTH-1:0]    issue_rs1_i,
   input  logic [REG_ADDR_WIDTH-1:0]    issue_rs2_i,
   input  logic                         issue_use_rs1_i,
   input  logic                         issue_use_rs2_i,
   input  logic [REG_ADDR_WIDTH-1:0]    issue_rd_i,
   input  logic                         issue_wb_i,
   input  logic                         issue_load_i,
   input  logic                         issue_serial_i,
   input  logic                         alu_wb_valid_i,
   input  logic [REG_ADDR_WIDTH-1:0]    alu_wb_addr_i,
   input  logic                         lsu_wb_valid_i,
   input  logic [REG_ADDR_WIDTH-1:0]    lsu_wb_addr_i,
   input  logic                         serial_done_i,
   input  logic                         jmp_taken_i,
   output logic                         flush_o,
   output logic [2**REG_ADDR_WIDTH-1:0] sb_pending_o,
   output logic [2:0]                   loads_outst_o
);
   localparam int NREG = 2**REG_ADDR_WIDTH;
   typedef enum logic [1:0] {RUN, SERIAL, FLUSH} state_e;
   state_e          state_q, state_d;
   logic [3:0]      fcnt_q, fcnt_d;
   logic [NREG-1:0] pend_q, pend_d;
   logic [2:0]      loads_q, loads_d;
   logic            hazard, load_stall, serial_blk, fire;

   // Issue decision from registered tracking state (no bypass of same-cycle writebacks)
   always_comb begin
      hazard        = (issue_use_rs1_i & (|issue_rs1_i) & pend_q[issue_rs1_i])
                    | (issue_use_rs2_i & (|issue_rs2_i) & pend_q[issue_rs2_i])
                    | (issue_wb_i & (|issue_rd_i) & pend_q[issue_rd_i]);
      load_stall    = issue_load_i & (loads_q == 3'(MAX_LOADS));
      serial_blk    = issue_serial_i & ((|pend_q) | (|loads_q));
      issue_ready_o = rstn_i & (state_q == RUN) & ~jmp_taken_i & ~hazard & ~load_stall & ~serial_blk;
      fire          = issue_valid_i & issue_ready_o;
   end

   // Scoreboard next value: clears applied first so a same-cycle new writer wins
   always_comb begin
      pend_d = pend_q;
      if (alu_wb_valid_i) pend_d[alu_wb_addr_i] = 1'b0;
      if (lsu_wb_valid_i) pend_d[lsu_wb_addr_i] = 1'b0;
      if (fire & issue_wb_i) pend_d[issue_rd_i] = 1'b1;
      pend_d[0] = 1'b0;
   end

   // Outstanding loads: writeback at zero count is ignored
   always_comb loads_d = loads_q + 3'(fire & issue_load_i) - 3'(lsu_wb_valid_i & (|loads_q));

   // Sequencer next state: a taken jump overrides everything and restarts the flush window
   always_comb begin
      state_d = state_q;
      fcnt_d  = fcnt_q;
      if (jmp_taken_i) begin
         state_d = FLUSH;
         fcnt_d  = 4'(FLUSH_CYCLES - 1);
      end else if (fire & issue_serial_i) begin
         state_d = SERIAL;
      end else if (state_q == SERIAL) begin
         state_d = serial_done_i ? RUN : SERIAL;
      end else if (state_q == FLUSH) begin
         state_d = (fcnt_q == 4'd0) ? RUN : FLUSH;
         fcnt_d  = (fcnt_q == 4'd0) ? fcnt_q : fcnt_q - 4'd1;
      end
   end

   // State registers; reset discards all in-flight tracking
   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         state_q <= RUN;
         fcnt_q  <= 4'd0;
         pend_q  <= '0;
         loads_q <= 3'd0;
      end else begin
         state_q <= state_d;
         fcnt_q  <= fcnt_d;
         pend_q  <= pend_d;
         loads_q <= loads_d;
      end
   end

   assign flush_o       = (state_q == FLUSH);
   assign sb_pending_o  = pend_q;
   assign loads_outst_o = loads_q;
endmodule

// File: tb/tb_jedro_1_issue_ctrl.sv
// tb_jedro_1_issue_ctrl: directed scenarios plus randomized run against a behavioural issue model
module tb_jedro_1_issue_ctrl;
   localparam int AW = 5;
   localparam int ML = 2;
   localparam int FC = 2;

   logic          clk_i = 0;
   logic          rstn_i = 0;
   logic          issue_valid_i, issue_ready_o;
   logic [AW-1:0] issue_rs1_i, issue_rs2_i, issue_rd_i;
   logic          issue_use_rs1_i, issue_use_rs2_i, issue_wb_i, issue_load_i, issue_serial_i;
   logic          alu_wb_valid_i, lsu_wb_valid_i;
   logic [AW-1:0] alu_wb_addr_i, lsu_wb_addr_i;
   logic          serial_done_i, jmp_taken_i, flush_o;
   logic [31:0]   sb_pending_o;
   logic [2:0]    loads_outst_o;

   int checks = 0;
   int passes = 0;

   bit m_pend[32];
   int m_loads, m_flush;
   bit m_serial;

   jedro_1_issue_ctrl #(.REG_ADDR_WIDTH(AW), .MAX_LOADS(ML), .FLUSH_CYCLES(FC)) dut (
      .clk_i(clk_i), .rstn_i(rstn_i),
      .issue_valid_i(issue_valid_i), .issue_ready_o(issue_ready_o),
      .issue_rs1_i(issue_rs1_i), .issue_rs2_i(issue_rs2_i),
      .issue_use_rs1_i(issue_use_rs1_i), .issue_use_rs2_i(issue_use_rs2_i),
      .issue_rd_i(issue_rd_i), .issue_wb_i(issue_wb_i), .issue_load_i(issue_load_i),
      .issue_serial_i(issue_serial_i),
      .alu_wb_valid_i(alu_wb_valid_i), .alu_wb_addr_i(alu_wb_addr_i),
      .lsu_wb_valid_i(lsu_wb_valid_i), .lsu_wb_addr_i(lsu_wb_addr_i),
      .serial_done_i(serial_done_i), .jmp_taken_i(jmp_taken_i),
      .flush_o(flush_o), .sb_pending_o(sb_pending_o), .loads_outst_o(loads_outst_o)
   );

   always #5 clk_i = ~clk_i;

   task automatic idle();
      issue_valid_i = 0; issue_rs1_i = 0; issue_rs2_i = 0; issue_rd_i = 0;
      issue_use_rs1_i = 0; issue_use_rs2_i = 0; issue_wb_i = 0; issue_load_i = 0; issue_serial_i = 0;
      alu_wb_valid_i = 0; alu_wb_addr_i = 0; lsu_wb_valid_i = 0; lsu_wb_addr_i = 0;
      serial_done_i = 0; jmp_taken_i = 0;
   endtask

   task automatic instr(input bit v, input int rs1, input bit u1, input int rs2, input bit u2,
                        input int rd, input bit wb, input bit ld, input bit ser);
      issue_valid_i = v; issue_rs1_i = AW'(rs1); issue_use_rs1_i = u1; issue_rs2_i = AW'(rs2);
      issue_use_rs2_i = u2; issue_rd_i = AW'(rd); issue_wb_i = wb; issue_load_i = ld; issue_serial_i = ser;
   endtask

   task automatic cyc();
      @(negedge clk_i);
      idle();
   endtask

   function automatic int m_busy();
      int n = 0;
      for (int i = 0; i < 32; i++) n += m_pend[i];
      return n;
   endfunction

   function automatic bit m_ready();
      bit haz = (issue_use_rs1_i && issue_rs1_i != 0 && m_pend[issue_rs1_i])
             || (issue_use_rs2_i && issue_rs2_i != 0 && m_pend[issue_rs2_i])
             || (issue_wb_i && issue_rd_i != 0 && m_pend[issue_rd_i]);
      return m_flush == 0 && !m_serial && !jmp_taken_i && !haz
          && !(issue_load_i && m_loads == ML)
          && !(issue_serial_i && (m_busy() > 0 || m_loads > 0));
   endfunction

   function automatic logic [31:0] m_vec();
      logic [31:0] v = '0;
      for (int i = 0; i < 32; i++) v[i] = m_pend[i];
      return v;
   endfunction

   task automatic m_reset();
      for (int i = 0; i < 32; i++) m_pend[i] = 0;
      m_loads = 0; m_flush = 0; m_serial = 0;
   endtask

   task automatic m_step();
      bit fire = issue_valid_i && m_ready();
      int dec = (lsu_wb_valid_i && m_loads > 0) ? 1 : 0;
      if (alu_wb_valid_i) m_pend[alu_wb_addr_i] = 0;
      if (lsu_wb_valid_i) m_pend[lsu_wb_addr_i] = 0;
      if (fire && issue_wb_i && issue_rd_i != 0) m_pend[issue_rd_i] = 1;
      m_loads = m_loads + ((fire && issue_load_i) ? 1 : 0) - dec;
      if (jmp_taken_i) begin m_flush = FC; m_serial = 0; end
      else if (m_flush > 0) m_flush--;
      else if (m_serial) m_serial = !serial_done_i;
      else if (fire && issue_serial_i) m_serial = 1;
   endtask

   task automatic test_reset();
      idle();
      rstn_i = 0;
      @(negedge clk_i); #1;
      checks++; if (issue_ready_o !== 1'b0) $display("FAIL reset_ready: got %b want 0", issue_ready_o); else passes++;
      checks++; if (flush_o !== 1'b0) $display("FAIL reset_flush: got %b want 0", flush_o); else passes++;
      checks++; if (sb_pending_o !== 32'h0) $display("FAIL reset_pending: got %h want 0", sb_pending_o); else passes++;
      checks++; if (loads_outst_o !== 3'd0) $display("FAIL reset_loads: got %0d want 0", loads_outst_o); else passes++;
      @(negedge clk_i); rstn_i = 1; #1;
      checks++; if (issue_ready_o !== 1'b1) $display("FAIL reset_release_ready: got %b want 1", issue_ready_o); else passes++;
   endtask

   task automatic test_raw();
      cyc(); instr(1, 0, 0, 0, 0, 5, 1, 0, 0); #1;
      checks++; if (issue_ready_o !== 1'b1) $display("FAIL raw_first: got %b want 1", issue_ready_o); else passes++;
      cyc(); instr(1, 5, 1, 0, 0, 6, 1, 0, 0); #1;
      checks++; if (sb_pending_o !== 32'h20) $display("FAIL raw_pend5: got %h want 20", sb_pending_o); else passes++;
      checks++; if (issue_ready_o !== 1'b0) $display("FAIL raw_stall: got %b want 0", issue_ready_o); else passes++;
      cyc(); instr(1, 5, 1, 0, 0, 6, 1, 0, 0); alu_wb_valid_i = 1; alu_wb_addr_i = 5; #1;
      checks++; if (issue_ready_o !== 1'b0) $display("FAIL raw_no_bypass: got %b want 0", issue_ready_o); else passes++;
      cyc(); instr(1, 5, 1, 0, 0, 6, 1, 0, 0); #1;
      checks++; if (issue_ready_o !== 1'b1) $display("FAIL raw_resume: got %b want 1", issue_ready_o); else passes++;
      cyc(); alu_wb_valid_i = 1; alu_wb_addr_i = 6; #1;
      checks++; if (sb_pending_o !== 32'h40) $display("FAIL raw_pend6: got %h want 40", sb_pending_o); else passes++;
      cyc(); #1;
      checks++; if (sb_pending_o !== 32'h0) $display("FAIL raw_clean: got %h want 0", sb_pending_o); else passes++;
   endtask

   task automatic test_x0();
      for (int i = 0; i < 3; i++) begin
         cyc(); instr(1, 0, 1, 0, 1, 0, 1, 0, 0); #1;
         checks++; if (issue_ready_o !== 1'b1) $display("FAIL x0_ready[%0d]: got %b want 1", i, issue_ready_o); else passes++;
         checks++; if (sb_pending_o !== 32'h0) $display("FAIL x0_pending[%0d]: got %h want 0", i, sb_pending_o); else passes++;
      end
   endtask

   task automatic test_loads();
      cyc(); instr(1, 0, 0, 0, 0, 1, 1, 1, 0); #1;
      checks++; if (issue_ready_o !== 1'b1) $display("FAIL ld_first: got %b want 1", issue_ready_o); else passes++;
      cyc(); instr(1, 0, 0, 0, 0, 2, 1, 1, 0); lsu_wb_valid_i = 1; lsu_wb_addr_i = 1; #1;
      checks++; if (loads_outst_o !== 3'd1) $display("FAIL ld_cnt1: got %0d want 1", loads_outst_o); else passes++;
      checks++; if (issue_ready_o !== 1'b1) $display("FAIL ld_second: got %b want 1", issue_ready_o); else passes++;
      cyc(); instr(1, 0, 0, 0, 0, 3, 1, 1, 0); #1;
      checks++; if (loads_outst_o !== 3'd1) $display("FAIL ld_fire_and_wb: got %0d want 1", loads_outst_o); else passes++;
      checks++; if (sb_pending_o !== 32'h4) $display("FAIL ld_pend: got %h want 4", sb_pending_o); else passes++;
      cyc(); instr(1, 0, 0, 0, 0, 4, 1, 1, 0); #1;
      checks++; if (loads_outst_o !== 3'd2) $display("FAIL ld_cnt2: got %0d want 2", loads_outst_o); else passes++;
      checks++; if (issue_ready_o !== 1'b0) $display("FAIL ld_stall: got %b want 0", issue_ready_o); else passes++;
      cyc(); instr(1, 0, 0, 0, 0, 9, 1, 0, 0); #1;
      checks++; if (issue_ready_o !== 1'b1) $display("FAIL ld_nonload_in_stall: got %b want 1", issue_ready_o); else passes++;
      cyc(); lsu_wb_valid_i = 1; lsu_wb_addr_i = 2; #1;
      checks++; if (loads_outst_o !== 3'd2) $display("FAIL ld_hold2: got %0d want 2", loads_outst_o); else passes++;
      cyc(); lsu_wb_valid_i = 1; lsu_wb_addr_i = 3; #1;
      checks++; if (loads_outst_o !== 3'd1) $display("FAIL ld_dec1: got %0d want 1", loads_outst_o); else passes++;
      cyc(); alu_wb_valid_i = 1; alu_wb_addr_i = 9; lsu_wb_valid_i = 1; lsu_wb_addr_i = 0; #1;
      checks++; if (loads_outst_o !== 3'd0) $display("FAIL ld_dec0: got %0d want 0", loads_outst_o); else passes++;
      checks++; if (sb_pending_o !== 32'h200) $display("FAIL ld_pend9: got %h want 200", sb_pending_o); else passes++;
      cyc(); #1;
      checks++; if (loads_outst_o !== 3'd0) $display("FAIL ld_underflow: got %0d want 0", loads_outst_o); else passes++;
      checks++; if (sb_pending_o !== 32'h0) $display("FAIL ld_clean: got %h want 0", sb_pending_o); else passes++;
   endtask

   task automatic test_collision();
      cyc(); instr(1, 0, 0, 0, 0, 7, 1, 0, 0); alu_wb_valid_i = 1; alu_wb_addr_i = 7; #1;
      checks++; if (issue_ready_o !== 1'b1) $display("FAIL coll_ready: got %b want 1", issue_ready_o); else passes++;
      cyc(); alu_wb_valid_i = 1; alu_wb_addr_i = 7; #1;
      checks++; if (sb_pending_o !== 32'h80) $display("FAIL coll_set_wins: got %h want 80", sb_pending_o); else passes++;
      cyc(); #1;
      checks++; if (sb_pending_o !== 32'h0) $display("FAIL coll_clean: got %h want 0", sb_pending_o); else passes++;
   endtask

   task automatic test_serial();
      cyc(); instr(1, 0, 0, 0, 0, 10, 1, 1, 0); #1;
      checks++; if (issue_ready_o !== 1'b1) $display("FAIL ser_load: got %b want 1", issue_ready_o); else passes++;
      cyc(); instr(1, 0, 0, 0, 0, 11, 1, 0, 1); #1;
      checks++; if (issue_ready_o !== 1'b0) $display("FAIL ser_blocked: got %b want 0", issue_ready_o); else passes++;
      cyc(); instr(1, 0, 0, 0, 0, 11, 1, 0, 1); lsu_wb_valid_i = 1; lsu_wb_addr_i = 10; #1;
      checks++; if (issue_ready_o !== 1'b0) $display("FAIL ser_blocked_wb: got %b want 0", issue_ready_o); else passes++;
      cyc(); instr(1, 0, 0, 0, 0, 11, 1, 0, 1); #1;
      checks++; if (issue_ready_o !== 1'b1) $display("FAIL ser_fire: got %b want 1", issue_ready_o); else passes++;
      cyc(); instr(1, 0, 0, 0, 0, 12, 1, 0, 0); alu_wb_valid_i = 1; alu_wb_addr_i = 11; #1;
      checks++; if (issue_ready_o !== 1'b0) $display("FAIL ser_busy: got %b want 0", issue_ready_o); else passes++;
      cyc(); instr(1, 0, 0, 0, 0, 12, 1, 0, 0); serial_done_i = 1; #1;
      checks++; if (issue_ready_o !== 1'b0) $display("FAIL ser_done_cycle: got %b want 0", issue_ready_o); else passes++;
      cyc(); instr(0, 0, 0, 0, 0, 12, 1, 0, 0); #1;
      checks++; if (issue_ready_o !== 1'b1) $display("FAIL ser_resume: got %b want 1", issue_ready_o); else passes++;
   endtask

   task automatic test_flush();
      cyc(); instr(1, 0, 0, 0, 0, 20, 1, 0, 0); jmp_taken_i = 1; #1;
      checks++; if (issue_ready_o !== 1'b0) $display("FAIL fl_jmp_ready: got %b want 0", issue_ready_o); else passes++;
      cyc(); jmp_taken_i = 1; #1;
      checks++; if (flush_o !== 1'b1) $display("FAIL fl_c11: got %b want 1", flush_o); else passes++;
      checks++; if (issue_ready_o !== 1'b0) $display("FAIL fl_c11_ready: got %b want 0", issue_ready_o); else passes++;
      cyc(); #1;
      checks++; if (flush_o !== 1'b1) $display("FAIL fl_c12: got %b want 1", flush_o); else passes++;
      cyc(); #1;
      checks++; if (flush_o !== 1'b1) $display("FAIL fl_c13: got %b want 1", flush_o); else passes++;
      checks++; if (issue_ready_o !== 1'b0) $display("FAIL fl_c13_ready: got %b want 0", issue_ready_o); else passes++;
      cyc(); #1;
      checks++; if (flush_o !== 1'b0) $display("FAIL fl_c14: got %b want 0", flush_o); else passes++;
      checks++; if (issue_ready_o !== 1'b1) $display("FAIL fl_c14_ready: got %b want 1", issue_ready_o); else passes++;
      cyc(); instr(1, 0, 0, 0, 0, 15, 1, 1, 0); #1;
      checks++; if (issue_ready_o !== 1'b1) $display("FAIL fl_load: got %b want 1", issue_ready_o); else passes++;
      cyc(); jmp_taken_i = 1; #1;
      checks++; if (sb_pending_o !== 32'h8000) $display("FAIL fl_pend15: got %h want 8000", sb_pending_o); else passes++;
      cyc(); jmp_taken_i = 1; #1;
      checks++; if (loads_outst_o !== 3'd1) $display("FAIL fl_keep_loads: got %0d want 1", loads_outst_o); else passes++;
      cyc(); rstn_i = 0; #1;
      checks++; if (flush_o !== 1'b0) $display("FAIL fl_rst_flush: got %b want 0", flush_o); else passes++;
      checks++; if (issue_ready_o !== 1'b0) $display("FAIL fl_rst_ready: got %b want 0", issue_ready_o); else passes++;
      checks++; if (sb_pending_o !== 32'h0 || loads_outst_o !== 3'd0)
         $display("FAIL fl_rst_track: got %h/%0d want 0/0", sb_pending_o, loads_outst_o); else passes++;
      cyc(); rstn_i = 1; #1;
      checks++; if (issue_ready_o !== 1'b1) $display("FAIL fl_rst_release: got %b want 1", issue_ready_o); else passes++;
   endtask

   task automatic test_random();
      cyc(); rstn_i = 0;
      cyc(); rstn_i = 1;
      m_reset();
      for (int n = 0; n < 500; n++) begin
         cyc();
         instr($urandom_range(0, 3) != 0, $urandom_range(0, 7), $urandom_range(0, 1), $urandom_range(0, 7),
               $urandom_range(0, 1), $urandom_range(0, 7), $urandom_range(0, 1), $urandom_range(0, 3) == 0,
               $urandom_range(0, 9) == 0);
         alu_wb_valid_i = $urandom_range(0, 1); alu_wb_addr_i = AW'($urandom_range(0, 7));
         lsu_wb_valid_i = $urandom_range(0, 2) == 0; lsu_wb_addr_i = AW'($urandom_range(0, 7));
         serial_done_i = $urandom_range(0, 3) == 0; jmp_taken_i = $urandom_range(0, 15) == 0;
         #1;
         checks++; if (issue_ready_o !== m_ready()) $display("FAIL rnd_ready[%0d]: got %b want %b", n, issue_ready_o, m_ready()); else passes++;
         checks++; if (flush_o !== (m_flush > 0)) $display("FAIL rnd_flush[%0d]: got %b want %b", n, flush_o, m_flush > 0); else passes++;
         checks++; if (sb_pending_o !== m_vec()) $display("FAIL rnd_pending[%0d]: got %h want %h", n, sb_pending_o, m_vec()); else passes++;
         checks++; if (loads_outst_o !== 3'(m_loads)) $display("FAIL rnd_loads[%0d]: got %0d want %0d", n, loads_outst_o, m_loads); else passes++;
         m_step();
      end
   endtask

   initial begin
      test_reset();
      test_raw();
      test_x0();
      test_loads();
      test_collision();
      test_serial();
      test_flush();
      test_random();
      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end
endmodule
